debounce_filter: RTL and testbench
==================================

DEBOUNCE_FILTER -- requirements
Module: debounce_filter

Interface
REQ-001 Parameter CH, default 4, number of independent filter channels (1..32).
REQ-002 Parameter DEPTH, default 4, consecutive accepted samples needed to change an output (2..255).
REQ-003 Parameter CW, default $clog2(DEPTH), per-channel counter width; not overridden by users.
REQ-004 clock  input  1  single rising-edge clock for all logic.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 sample_en  input  1  sampling strobe; logic advances only on clock edges where sample_en=1.
REQ-007 sig_in  input  CH  raw per-channel input levels.
REQ-008 sig_out  output  CH  filtered levels, registered.
REQ-009 rise  output  CH  one-clock pulse when sig_out[i] goes 0->1.
REQ-010 fall  output  CH  one-clock pulse when sig_out[i] goes 1->0.

Function
REQ-011 Each channel i SHALL own a CW-bit counter cnt[i] and be fully independent of other channels.
REQ-012 On an edge with sample_en=1 and sample s[i]==sig_out[i], cnt[i] SHALL clear to 0.
REQ-013 On an edge with sample_en=1, s[i]!=sig_out[i] and cnt[i]<DEPTH-1, cnt[i] SHALL increment by 1.
REQ-014 On an edge with sample_en=1, s[i]!=sig_out[i] and cnt[i]==DEPTH-1, sig_out[i] SHALL load s[i] and cnt[i] SHALL clear to 0.
REQ-015 Hence sig_out[i] SHALL change on the DEPTH-th consecutive sampled edge at the new level, never earlier; any sample at the old level restarts the count.
REQ-016 On an edge with sample_en=0, cnt, sig_out SHALL hold; rise and fall SHALL be 0.
REQ-017 rise[i]/fall[i] SHALL be registered and high for exactly the one clock following the edge on which sig_out[i] changed, coincident with the new sig_out value.
REQ-018 rise[i] and fall[i] SHALL never be high in the same cycle.
REQ-019 The counter SHALL never exceed DEPTH-1; no wrap-around.
REQ-020 Without the Configuration feature, s[i] SHALL be sig_in[i] directly.

Reset
REQ-021 While reset=1, sig_out, rise, fall, all cnt and all synchroniser flops SHALL be 0, asynchronously, regardless of clock or sample_en.
REQ-022 Reset asserted mid-count SHALL discard the partial count; after release counting restarts from 0 against sig_out=0.
REQ-023 First sampling edge after reset release SHALL be treated as a normal edge.

Configuration
REQ-024 Macro DEBOUNCE_SYNC_EN: when defined, each sig_in[i] SHALL pass through a 2-flop synchroniser clocked every clock edge (independent of sample_en), and s[i] SHALL be the second flop output, adding 2 clocks of latency.
REQ-025 When DEBOUNCE_SYNC_EN is undefined, no synchroniser flops SHALL exist and latency SHALL be as in REQ-015.

Verification
REQ-026 CH=4, DEPTH=4, sample_en=1, macro off: sig_in[0] 0->1 held -> sig_out[0]=1 after 4th edge, rise[0]=1 for one cycle, channels 1-3 stay 0.
REQ-027 Glitch: sig_in[1]=1 for 3 clocks then 0 -> sig_out[1] stays 0, rise[1] never pulses.
REQ-028 sample_en high every 3rd clock, sig_in[2]=1 held -> sig_out[2] rises on 4th strobed edge (clock 10-12), held between strobes.
REQ-029 sig_out[3]=1 then sig_in[3]=0 for 4 samples with one 1 after sample 2 -> fall delayed until 4 consecutive 0 samples after the 1; fall[3] single pulse.
REQ-030 Reset asserted after 2 of 4 samples, released, input still 1 -> sig_out changes only 4 samples after release; outputs 0 immediately on reset assertion without clock.
REQ-031 Macro on, DEPTH=4: sig_in[0] 0->1 -> sig_out[0]=1 after 6 clocks.

Source files
------------

// File: rtl/debounce_filter.sv
// debounce_filter: per-channel digital debounce for slow level inputs.
// Each channel must see DEPTH consecutive sampled edges at a new level before
// its filtered output follows; a single sample at the old level restarts the
// count. rise/fall are registered one-clock pulses that line up with the new
// sig_out value.
// Optional feature: define DEBOUNCE_SYNC_EN to put a 2-flop synchroniser in
// front of every channel. It runs on every clock and adds 2 clocks of latency.
module debounce_filter #(
  parameter int CH    = 4,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          sample_en,
  input  logic [CH-1:0] sig_in,
  output logic [CH-1:0] sig_out,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall
);

  localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [CH-1:0]         samp;
  logic [CH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [CH-1:0]         sig_out_q, sig_out_d;
  logic [CH-1:0]         rise_q, rise_d;
  logic [CH-1:0]         fall_q, fall_d;

`ifdef DEBOUNCE_SYNC_EN
  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;

  // Synchroniser next-state: a plain two-stage shift of the raw inputs.
  always_comb begin
    sync1_d = sig_in;
    sync2_d = sync1_q;
  end

  // Synchroniser flops run every clock, independent of the sampling strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign samp = sync2_q;
`else
  assign samp = sig_in;
`endif

  // Per-channel count/accept decision; channels never interact.
  always_comb begin
    cnt_d     = cnt_q;
    sig_out_d = sig_out_q;
    rise_d    = '0;
    fall_d    = '0;
    for (int i = 0; i < CH; i++) begin
      if (sample_en) begin
        if (samp[i] == sig_out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          // DEPTH-th consecutive sample at the new level: accept it.
          sig_out_d[i] = samp[i];
          cnt_d[i]     = '0;
          rise_d[i]    = samp[i];
          fall_d[i]    = ~samp[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_ONE;
        end
      end
    end
  end

  // Filter state and edge pulses, all cleared asynchronously by reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      sig_out_q <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      sig_out_q <= sig_out_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
    end
  end

  assign sig_out = sig_out_q;
  assign rise    = rise_q;
  assign fall    = fall_q;

endmodule

// File: tb/tb_debounce_filter.sv
// Directed bench for debounce_filter with CH=4, DEPTH=4.
module tb_debounce_filter;

  localparam int CH    = 4;
  localparam int DEPTH = 4;
`ifdef DEBOUNCE_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sample_en = 1'b0;
  logic [CH-1:0] sig_in = '0;
  logic [CH-1:0] sig_out, rise, fall;

  int n_vec = 0;
  int n_err = 0;

  debounce_filter #(.CH(CH), .DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .sample_en (sample_en),
    .sig_in    (sig_in),
    .sig_out   (sig_out),
    .rise      (rise),
    .fall      (fall)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [3:0] eo, input logic [3:0] er,
                           input logic [3:0] ef);
    check({tag, " sig_out"}, 32'(sig_out), 32'(eo));
    check({tag, " rise"},    32'(rise),    32'(er));
    check({tag, " fall"},    32'(fall),    32'(ef));
  endtask

  initial begin
    // Reset state, no clock edge needed.
    #2;
    check_all("reset", 4'b0000, 4'b0000, 4'b0000);
    tick();
    check_all("reset_clk", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;

    // Channel 0 goes high and stays; accepted on the 4th edge (plus sync latency).
    sample_en = 1'b1;
    sig_in    = 4'b0001;
    for (int k = 1; k <= DEPTH + SL + 1; k++) begin
      tick();
      check_all($sformatf("ch0_rise k%0d", k),
                (k >= DEPTH + SL) ? 4'b0001 : 4'b0000,
                (k == DEPTH + SL) ? 4'b0001 : 4'b0000,
                4'b0000);
    end

    // Channel 1 glitches high for 3 samples only: never accepted.
    sig_in = 4'b0011;
    for (int k = 1; k <= 8; k++) begin
      if (k == 4) sig_in = 4'b0001;
      tick();
      check_all($sformatf("ch1_glitch k%0d", k), 4'b0001, 4'b0000, 4'b0000);
    end

    // Channel 2 high with a strobe every 3rd clock: accepted on strobe 4 (clock 12).
    sig_in = 4'b0101;
    for (int k = 1; k <= 14; k++) begin
      sample_en = (k % 3 == 0);
      tick();
      check_all($sformatf("ch2_strobe k%0d", k),
                (k >= 12) ? 4'b0101 : 4'b0001,
                (k == 12) ? 4'b0100 : 4'b0000,
                4'b0000);
    end

    // Bring channel 3 high.
    sample_en = 1'b1;
    sig_in    = 4'b1101;
    for (int k = 1; k <= 4; k++) begin
      tick();
      check_all($sformatf("ch3_up k%0d", k),
                (k == 4) ? 4'b1101 : 4'b0101,
                (k == 4) ? 4'b1000 : 4'b0000,
                4'b0000);
    end

    // Channel 3 low samples 0,0,1,0,0,0,0: fall only after 4 zeros following the 1.
    for (int k = 1; k <= 8; k++) begin
      sig_in = (k == 3) ? 4'b1101 : 4'b0101;
      tick();
      check_all($sformatf("ch3_fall k%0d", k),
                (k >= 7) ? 4'b0101 : 4'b1101,
                4'b0000,
                (k == 7) ? 4'b1000 : 4'b0000);
    end

    // Reset mid-count: channel 3 has 2 samples at 1, then reset clears everything.
    sig_in = 4'b1101;
    tick();
    tick();
    check_all("pre_reset", 4'b0101, 4'b0000, 4'b0000);
    reset = 1'b1;
    #1;
    check_all("async_reset", 4'b0000, 4'b0000, 4'b0000);
    tick();
    check_all("reset_held", 4'b0000, 4'b0000, 4'b0000);
    reset = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check_all($sformatf("post_reset k%0d", k),
                (k >= 4) ? 4'b1101 : 4'b0000,
                (k == 4) ? 4'b1101 : 4'b0000,
                4'b0000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
